// File: rtl/alu_control_fsm.sv
// Multi-cycle control FSM for the Eka v1 core: fetch, decode, execute,
// memory and writeback sequencing with ALU, memory, register-file and PC strobes.
module alu_control_fsm #(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        instr_req,
    input  logic        instr_valid,
    input  logic [31:0] instruction,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [1:0]  ALU_Op,
    output logic        add_sub_sel,
    output logic        alu_src2_imm,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        instr_retired,
    output logic        illegal_instr
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WB,
        TRAP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] ir;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_add;
    logic       is_sub;
    logic       is_addi;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_bne;
    logic       is_branch;
    logic       is_mem;
    logic       is_legal;
    logic       br_taken;

    // Register and immediate fields belong to the datapath, not this unit.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{ir[24:15], ir[11:7]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            ir    <= 32'h0000_0013;
        end else begin
            state <= state_nxt;
            if (state == FETCH && instr_valid) begin
                ir <= instruction;
            end
        end
    end

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    assign is_add    = opcode == 7'b0110011 && funct3 == 3'b000
                    && funct7 == 7'b0000000;
    assign is_sub    = opcode == 7'b0110011 && funct3 == 3'b000
                    && funct7 == 7'b0100000;
    assign is_addi   = opcode == 7'b0010011 && funct3 == 3'b000;
    assign is_lw     = opcode == 7'b0000011 && funct3 == 3'b010;
    assign is_sw     = opcode == 7'b0100011 && funct3 == 3'b010;
    assign is_beq    = opcode == 7'b1100011 && funct3 == 3'b000;
    assign is_bne    = opcode == 7'b1100011 && funct3 == 3'b001;
    assign is_branch = is_beq | is_bne;
    assign is_mem    = is_lw | is_sw;
    assign is_legal  = is_add | is_sub | is_addi | is_mem | is_branch;

    // The ALU reports zero=0 when the operands are equal.
    assign br_taken = is_beq ? ~zero : zero;

    assign ALU_Op = 2'b00;

    always_comb begin
        state_nxt     = state;
        instr_req     = 1'b0;
        add_sub_sel   = 1'b0;
        alu_src2_imm  = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        instr_retired = 1'b0;
        illegal_instr = 1'b0;

        // Reset silences every strobe in the cycle it is sampled.
        if (!reset) begin
            case (state)
                FETCH: begin
                    instr_req = 1'b1;
                    if (instr_valid) begin
                        state_nxt = DECODE;
                    end
                end
                DECODE: begin
                    if (is_legal) begin
                        state_nxt = EXECUTE;
                    end else if (TRAP_ON_ILLEGAL) begin
                        state_nxt = TRAP;
                    end else begin
                        pc_write      = 1'b1;
                        instr_retired = 1'b1;
                        state_nxt     = FETCH;
                    end
                end
                EXECUTE: begin
                    add_sub_sel  = is_sub | is_branch;
                    alu_src2_imm = is_addi | is_mem;
                    if (is_branch) begin
                        pc_write      = 1'b1;
                        pc_src        = br_taken;
                        instr_retired = 1'b1;
                        state_nxt     = FETCH;
                    end else if (is_mem) begin
                        state_nxt = MEM;
                    end else begin
                        state_nxt = WB;
                    end
                end
                MEM: begin
                    add_sub_sel  = is_sub | is_branch;
                    alu_src2_imm = is_addi | is_mem;
                    mem_read     = is_lw;
                    mem_write    = is_sw;
                    if (mem_ready) begin
                        if (is_lw) begin
                            state_nxt = WB;
                        end else begin
                            pc_write      = 1'b1;
                            instr_retired = 1'b1;
                            state_nxt     = FETCH;
                        end
                    end
                end
                WB: begin
                    reg_write     = 1'b1;
                    mem_to_reg    = is_lw;
                    pc_write      = 1'b1;
                    instr_retired = 1'b1;
                    state_nxt     = FETCH;
                end
                TRAP: begin
                    illegal_instr = 1'b1;
                end
                default: begin
                    state_nxt = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_fsm.sv
// Scoreboard bench for alu_control_fsm: random and directed instructions
// against a per-instruction reference model, plus trap and reset-abort cases.
module tb_alu_control_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic        zero = 1'b0;
    logic        mem_ready;

    logic       instr_req, add_sub_sel, alu_src2_imm, mem_read, mem_write;
    logic       mem_to_reg, reg_write, pc_write, pc_src, instr_retired;
    logic       illegal_instr;
    logic [1:0] ALU_Op;

    logic       n_instr_req, n_add_sub_sel, n_alu_src2_imm, n_mem_read;
    logic       n_mem_write, n_mem_to_reg, n_reg_write, n_pc_write, n_pc_src;
    logic       n_instr_retired, n_illegal_instr;
    logic [1:0] n_ALU_Op;

    always #5 clk = ~clk;

    alu_control_fsm #(.TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .instr_req(instr_req),
        .instr_valid(instr_valid), .instruction(instruction), .zero(zero),
        .mem_ready(mem_ready), .ALU_Op(ALU_Op), .add_sub_sel(add_sub_sel),
        .alu_src2_imm(alu_src2_imm), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .pc_write(pc_write), .pc_src(pc_src),
        .instr_retired(instr_retired), .illegal_instr(illegal_instr)
    );

    alu_control_fsm #(.TRAP_ON_ILLEGAL(1'b0)) dut_n (
        .clk(clk), .reset(reset), .instr_req(n_instr_req),
        .instr_valid(instr_valid), .instruction(instruction), .zero(zero),
        .mem_ready(mem_ready), .ALU_Op(n_ALU_Op),
        .add_sub_sel(n_add_sub_sel), .alu_src2_imm(n_alu_src2_imm),
        .mem_read(n_mem_read), .mem_write(n_mem_write),
        .mem_to_reg(n_mem_to_reg), .reg_write(n_reg_write),
        .pc_write(n_pc_write), .pc_src(n_pc_src),
        .instr_retired(n_instr_retired), .illegal_instr(n_illegal_instr)
    );

    // Data memory model: ready after cur_stall cycles of an active strobe.
    int cur_stall = 0;
    int mem_cnt = 0;
    assign mem_ready = (mem_cnt >= cur_stall);

    always @(posedge clk) begin
        if (reset || !(mem_read || mem_write)) mem_cnt <= 0;
        else mem_cnt <= mem_cnt + 1;
    end

    typedef struct {
        logic [31:0] ins;
        int          lat;
        bit          psrc;
        int          rw;
        bit          m2r;
        bit          asub;
        bit          imm;
        int          rd;
        int          wr;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp,
                     $time);
        end
    endtask

    // Reference: per-instruction outcome from the instruction class alone.
    function automatic exp_t model(logic [31:0] ins, bit z, int stall);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        e = '{ins: ins, default: 0};
        if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) begin
            e.lat = 4; e.rw = 1;
        end else if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) begin
            e.lat = 4; e.rw = 1; e.asub = 1;
        end else if (op == 7'h13 && f3 == 3'd0) begin
            e.lat = 4; e.rw = 1; e.imm = 1;
        end else if (op == 7'h03 && f3 == 3'd2) begin
            e.lat = 5 + stall; e.rw = 1; e.m2r = 1; e.imm = 1;
            e.rd = stall + 1;
        end else if (op == 7'h23 && f3 == 3'd2) begin
            e.lat = 4 + stall; e.imm = 1; e.wr = stall + 1;
        end else if (op == 7'h63 && f3 == 3'd0) begin
            e.lat = 3; e.asub = 1; e.psrc = !z;
        end else if (op == 7'h63 && f3 == 3'd1) begin
            e.lat = 3; e.asub = 1; e.psrc = z;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] im;
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        im  = 12'($urandom);
        case ($urandom_range(0, 6))
            0: return {7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
            1: return {7'h20, rs2, rs1, 3'b000, rd, 7'b0110011};
            2: return {im, rs1, 3'b000, rd, 7'b0010011};
            3: return {im, rs1, 3'b010, rd, 7'b0000011};
            4: return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'b0100011};
            5: return {im[11:5], rs2, rs1, 3'b000, im[4:0], 7'b1100011};
            default: return {im[11:5], rs2, rs1, 3'b001, im[4:0], 7'b1100011};
        endcase
    endfunction

    // Monitor: accumulates strobes per instruction, compares at retire.
    bit active = 0;
    bit prev_reset = 1;
    int m_lat, m_pcw, m_rw, m_rd, m_wr;
    bit m_psrc, m_m2r, m_asub, m_imm;

    always @(negedge clk) begin
        if (reset) begin
            chk("reset_outs", {instr_req, ALU_Op, add_sub_sel, alu_src2_imm,
                mem_read, mem_write, mem_to_reg, reg_write, pc_write, pc_src,
                instr_retired, illegal_instr}, 0);
            chk("reset_outs_n", {n_instr_req, n_ALU_Op, n_add_sub_sel,
                n_alu_src2_imm, n_mem_read, n_mem_write, n_mem_to_reg,
                n_reg_write, n_pc_write, n_pc_src, n_instr_retired,
                n_illegal_instr}, 0);
            active = 0;
        end else begin
            if (prev_reset) begin
                chk("req_after_reset", instr_req, 1);
                chk("req_after_reset_n", n_instr_req, 1);
            end
            chk("alu_op", ALU_Op, 0);
            chk("rw_mw_excl", reg_write & mem_write, 0);
            chk("pcw_eq_ret", pc_write, instr_retired);
            if (mem_write) chk("sw_pcw_on_ready", pc_write, mem_ready);
            if (mem_read) chk("lw_no_pcw", pc_write, 0);
            if (!active && instr_req && instr_valid) begin
                active = 1;
                m_lat = 0; m_pcw = 0; m_rw = 0; m_rd = 0; m_wr = 0;
                m_psrc = 0; m_m2r = 0; m_asub = 0; m_imm = 0;
            end
            if (active) begin
                m_lat++;
                m_pcw += int'(pc_write);
                m_rw  += int'(reg_write);
                m_rd  += int'(mem_read);
                m_wr  += int'(mem_write);
                if (pc_write) m_psrc = pc_src;
                if (reg_write) m_m2r = mem_to_reg;
                m_asub |= add_sub_sel;
                m_imm  |= alu_src2_imm;
                if (instr_retired) begin
                    active = 0;
                    chk("sb_nonempty", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("latency", m_lat, e.lat);
                        chk("pc_write_cnt", m_pcw, 1);
                        chk("pc_src", m_psrc, e.psrc);
                        chk("reg_write_cnt", m_rw, e.rw);
                        chk("mem_to_reg", m_m2r, e.m2r);
                        chk("add_sub_sel", m_asub, e.asub);
                        chk("alu_src2_imm", m_imm, e.imm);
                        chk("mem_read_cycles", m_rd, e.rd);
                        chk("mem_write_cycles", m_wr, e.wr);
                    end
                end
            end
        end
        prev_reset = reset;
    end

    task automatic wait_accept();
        bit ok;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = instr_req && instr_valid;
        end
        chk("fetch_accept", ok, 1);
        @(posedge clk);
        #1;
        instr_valid = 0;
    endtask

    task automatic wait_retire();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = instr_retired;
        end
        chk("retire_seen", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input bit z,
                         input int stall, input int dly);
        sb.push_back(model(ins, z, stall));
        instruction = ins;
        zero = z;
        cur_stall = stall;
        instr_valid = 0;
        repeat (dly) begin
            @(posedge clk);
            #1;
        end
        instr_valid = 1;
        wait_accept();
        wait_retire();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int rw_seen;
        bit ok;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;

        issue(32'h002081B3, 0, 0, 0);
        issue(32'h402081B3, 0, 0, 0);
        issue(32'h00500093, 0, 0, 0);
        issue(32'h00208463, 0, 0, 0);
        issue(32'h00209463, 0, 0, 0);
        issue(32'h0000A183, 0, 4, 0);
        issue(32'h0030A023, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            issue(rand_instr(), 1'($urandom), $urandom_range(0, 3),
                  $urandom_range(0, 2));
        end

        // Reset in the second MEM cycle of a stalled load.
        instruction = 32'h0000A183;
        cur_stall = 20;
        instr_valid = 1;
        wait_accept();
        ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = mem_read;
        end
        chk("abort_mem_read_seen", ok, 1);
        @(posedge clk);
        #1;
        reset = 1;
        @(negedge clk);
        chk("abort_mem_read_off", mem_read, 0);
        @(posedge clk);
        #1;
        reset = 0;
        cur_stall = 0;
        rw_seen = 0;
        repeat (8) begin
            @(negedge clk);
            rw_seen += int'(reg_write);
        end
        chk("abort_no_reg_write", rw_seen, 0);

        // Illegal instruction on both parameterisations.
        @(posedge clk);
        #1;
        instruction = 32'hFFFFFFFF;
        instr_valid = 1;
        wait_accept();
        @(negedge clk);
        chk("nop_pc_write", n_pc_write, 1);
        chk("nop_pc_src", n_pc_src, 0);
        chk("nop_retired", n_instr_retired, 1);
        chk("trap_decode_no_pcw", pc_write, 0);
        @(negedge clk);
        chk("nop_back_to_fetch", n_instr_req, 1);
        instr_valid = 1;
        repeat (8) begin
            @(negedge clk);
            chk("trap_illegal", illegal_instr, 1);
            chk("trap_no_req", instr_req, 0);
            chk("trap_no_pcw", pc_write, 0);
        end
        @(posedge clk);
        #1;
        reset = 1;
        instr_valid = 0;
        @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        chk("trap_cleared", illegal_instr, 0);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_control_fsm.md
Name: alu_control_fsm

Overview:
- Multi-cycle control unit for the Eka v1 core. It is the initiator side of the ALU interface.
- Fetches and latches one instruction, decodes it, and drives ALU_Op, add_sub_sel, operand selects, and memory/register-file/PC strobes. It consumes the ALU's zero flag to resolve branches.
- Sits between the instruction/data memory ports and the datapath containing the ALU.

Parameters:
- TRAP_ON_ILLEGAL, 1, 1: unsupported instruction enters TRAP and halts until reset; 0: treated as NOP (PC advances).

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_req  output  1  request instruction fetch at current PC.
- instr_valid  input  1  instruction memory returns data this cycle.
- instruction  input  32  fetched instruction word; sampled when instr_req && instr_valid.
- zero  input  1  ALU flag; HIGH when alu_src1 != alu_src2, LOW when equal.
- mem_ready  input  1  data memory has completed the current read/write.
- ALU_Op  output  2  ALU operation; always 2'b00 (add/sub) for the supported set.
- add_sub_sel  output  1  0 = add, 1 = subtract.
- alu_src2_imm  output  1  0 = rs2 operand, 1 = sign-extended immediate.
- mem_read  output  1  data memory read strobe.
- mem_write  output  1  data memory write strobe.
- mem_to_reg  output  1  writeback source: 0 = ALU_result, 1 = load data.
- reg_write  output  1  register-file write enable, one-cycle pulse.
- pc_write  output  1  PC update, one-cycle pulse.
- pc_src  output  1  0 = PC+4, 1 = branch target; valid only with pc_write.
- instr_retired  output  1  one-cycle pulse per completed instruction.
- illegal_instr  output  1  HIGH while in TRAP.

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEM, WB, TRAP. Outputs are Moore-style, from state plus the latched instruction register (IR).
- Reset:
  - reset high forces the state to FETCH, clears IR to 32'h0000_0013 (NOP), and forces every output to 0 in that cycle.
  - Reset mid-operation aborts immediately; no strobe is issued in the reset cycle.
- FETCH:
  - instr_req=1.
  - On instr_valid: IR <= instruction; next state is DECODE.
  - Otherwise stay in FETCH indefinitely.
- DECODE (1 cycle). Supported set (opcode/funct3/funct7):
  - ADD 0110011/000/0000000
  - SUB 0110011/000/0100000
  - ADDI 0010011/000
  - LW 0000011/010
  - SW 0100011/010
  - BEQ 1100011/000
  - BNE 1100011/001
  - Supported instruction: next state is EXECUTE.
  - Anything else: TRAP if TRAP_ON_ILLEGAL=1; else go to FETCH with pc_write=1, pc_src=0, instr_retired=1 asserted in that DECODE cycle.
- EXECUTE. ALU_Op=00 always. add_sub_sel=1 for SUB/BEQ/BNE, 0 otherwise. alu_src2_imm=1 for ADDI/LW/SW.
  - ADD/SUB/ADDI: next state WB.
  - LW/SW: next state MEM.
  - BEQ: taken when zero==0. BNE: taken when zero==1.
  - Branches: pc_write=1, pc_src=taken, instr_retired=1 in this cycle; next state FETCH.
- MEM. ALU outputs held as in EXECUTE.
  - mem_read (LW) or mem_write (SW) stays high until mem_ready.
  - LW + mem_ready: next state WB.
  - SW + mem_ready: pc_write=1, pc_src=0, instr_retired=1 in that cycle; next state FETCH.
  - mem_ready high in the first MEM cycle completes in 1 cycle.
- WB:
  - reg_write=1, pc_write=1, pc_src=0, instr_retired=1.
  - mem_to_reg=1 for LW only.
  - Next state FETCH.
  - rd=x0 still pulses reg_write; the register file ignores it.
- TRAP: illegal_instr=1, all other outputs 0; stays until reset.
- Minimum latency (instr_valid and mem_ready high immediately):
  - BEQ/BNE: 3 cycles.
  - ADD/SUB/ADDI/SW: 4 cycles.
  - LW: 5 cycles.
- Invariants:
  - Exactly one pc_write and one instr_retired per instruction.
  - reg_write is never asserted together with mem_write.
  - instr_valid outside FETCH is ignored.

Test Plan:
- Reset held 3 cycles, then released; instr_valid=1 with 32'h002081B3 (ADD x3,x1,x2). Required: all outputs 0 during reset; instr_req=1 in the first cycle after reset; reg_write, pc_write and instr_retired each pulse once in cycle 4 with add_sub_sel=0.
- SUB 32'h402081B3 then ADDI 32'h00500093. Required: add_sub_sel=1 in SUB EXECUTE; alu_src2_imm=1, add_sub_sel=0 in ADDI EXECUTE; two retire pulses.
- BEQ 32'h00208463 with zero=0 in EXECUTE, then BNE 32'h00209463 with zero=0. Required: BEQ gives pc_write=1, pc_src=1; BNE gives pc_src=0; 3 cycles each; no reg_write.
- LW 32'h0000A183 with mem_ready low for 4 cycles, then SW 32'h0030A023 with mem_ready immediate. Required: mem_read held 5 cycles, then a WB cycle with mem_to_reg=1 and reg_write=1; SW gives mem_write for 1 cycle with pc_write in that same cycle and no reg_write.
- Illegal 32'hFFFFFFFF. Required: TRAP_ON_ILLEGAL=1 gives illegal_instr=1 permanently and instr_req=0 until reset; TRAP_ON_ILLEGAL=0 gives DECODE cycle with pc_write=1, pc_src=0, then FETCH.
- Reset asserted in the second MEM cycle of a stalled LW. Required: mem_read=0 that cycle; next cycle FETCH with instr_req=1; no reg_write ever issued for the aborted LW.
